gemm_stream_ctrl: RTL and testbench

Byte-stream front end and result back end for the 2x2 `gemm` core (Cout = 2·A·B + 1·C·D, 8-bit elements packed into 32-bit words). It accepts a 16-byte operand stream over a valid/ready handshake and packs it into the A, B, C and D words that drive `gemm`. It waits out the core's registered latency, captures Cout, and streams the 4 result bytes out over a second valid/ready handshake. It sits between the system byte interconnect and an instantiated `gemm`. The bench connects the two directly.

---
 rtl/gemm_stream_ctrl.sv | 110 +++++++++++
 tb/tb_gemm_stream_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_stream_ctrl.sv
// rtl/gemm_stream_ctrl.sv - byte-stream operand loader and result streamer for the 2x2 gemm core
// Packs 16 operand bytes into A..D, waits out the core latency, then streams Cout back out MSB first.
module gemm_stream_ctrl #(
  parameter int GEMM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] A_o,
  output logic [31:0] B_o,
  output logic [31:0] C_o,
  output logic [31:0] D_o,
  input  logic [31:0] Cout_i,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy
);

  localparam int WAIT_W = (GEMM_LAT < 1) ? 1 : $clog2(GEMM_LAT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GEMM_LAT);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_COMPUTE,
    ST_SEND
  } state_t;

  state_t            r_state;
  logic [3:0]        r_count;
  logic [WAIT_W-1:0] r_wait;
  logic [1:0]        r_idx;
  logic [127:0]      r_ops;
  logic [31:0]       r_result;
  logic              r_s_ready;
  logic              r_m_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_LOAD;
      r_count   <= 4'd0;
      r_wait    <= '0;
      r_idx     <= 2'd0;
      r_ops     <= 128'd0;
      r_result  <= 32'd0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_s_ready <= 1'b1;
          if (s_valid && r_s_ready) begin
            // Byte n lands in element n; ~count maps index 0 onto the top byte of A.
            r_ops[{~r_count, 3'b000} +: 8] <= s_data;
            if (r_count == 4'd15) begin
              r_state   <= ST_COMPUTE;
              r_count   <= 4'd0;
              r_wait    <= '0;
              r_s_ready <= 1'b0;
            end else begin
              r_count <= r_count + 4'd1;
            end
          end
        end

        ST_COMPUTE: begin
          if (r_wait == WAIT_LAST) begin
            r_state   <= ST_SEND;
            r_result  <= Cout_i;
            r_idx     <= 2'd0;
            r_m_valid <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end

        ST_SEND: begin
          if (r_m_valid && m_ready) begin
            if (r_idx == 2'd3) begin
              r_state   <= ST_LOAD;
              r_idx     <= 2'd0;
              r_m_valid <= 1'b0;
              r_s_ready <= 1'b1;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end

        default: begin
          r_state   <= ST_LOAD;
          r_s_ready <= 1'b0;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign A_o     = r_ops[127:96];
  assign B_o     = r_ops[95:64];
  assign C_o     = r_ops[63:32];
  assign D_o     = r_ops[31:0];
  assign m_data  = r_result[{~r_idx, 3'b000} +: 8];
  assign busy    = (r_state != ST_LOAD) || (r_count != 4'd0);

endmodule

// File: tb/tb_gemm_stream_ctrl.sv
// tb/tb_gemm_stream_ctrl.sv - self-checking bench for gemm_stream_ctrl with a behavioural gemm core
// A transaction-level model predicts handshakes, operand words and result bytes each cycle.
module tb_gemm_stream_ctrl;

  localparam int GEMM_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] A_o, B_o, C_o, D_o;
  logic [31:0] cout_q = 32'd0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  gemm_stream_ctrl #(.GEMM_LAT(GEMM_LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .A_o     (A_o),
    .B_o     (B_o),
    .C_o     (C_o),
    .D_o     (D_o),
    .Cout_i  (cout_q),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic int el(input logic [31:0] w, input int i, input int j);
    return int'(w[31 - 8*(2*i + j) -: 8]);
  endfunction

  function automatic logic [31:0] gemm_fn(input logic [31:0] a, b, c, d);
    logic [31:0] r;
    int s;
    r = 32'd0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++)
          s += 2 * el(a, i, k) * el(b, k, j) + el(c, i, k) * el(d, k, j);
        r[31 - 8*(2*i + j) -: 8] = s[7:0];
      end
    end
    return r;
  endfunction

  // Stand-in for the gemm core: Cout registered one edge after the operands.
  always @(posedge clk) cout_q <= gemm_fn(A_o, B_o, C_o, D_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Transaction-level model
  logic [7:0] mdl_ops[16];
  logic [7:0] mdl_q[$];
  int         mdl_in = 0;
  int         mdl_wait = 0;
  bit         mdl_sready = 1'b0;
  logic [31:0] mdl_res;

  initial for (int i = 0; i < 16; i++) mdl_ops[i] = 8'd0;

  function automatic logic [31:0] mdl_word(input int w);
    return {mdl_ops[4*w], mdl_ops[4*w+1], mdl_ops[4*w+2], mdl_ops[4*w+3]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_in = 0;
      mdl_wait = 0;
      mdl_q.delete();
      mdl_sready = 1'b0;
      for (int i = 0; i < 16; i++) mdl_ops[i] = 8'd0;
    end else begin
      if (mdl_sready && s_valid) begin
        mdl_ops[mdl_in] = s_data;
        mdl_in++;
        if (mdl_in == 16) begin
          mdl_in = 0;
          mdl_wait = GEMM_LAT + 1;
        end
      end else if (mdl_wait > 0) begin
        mdl_wait--;
        if (mdl_wait == 0) begin
          mdl_res = gemm_fn(mdl_word(0), mdl_word(1), mdl_word(2), mdl_word(3));
          for (int b = 0; b < 4; b++) mdl_q.push_back(mdl_res[31 - 8*b -: 8]);
        end
      end else if (mdl_q.size() > 0 && m_ready) begin
        void'(mdl_q.pop_front());
      end
      mdl_sready = (mdl_wait == 0) && (mdl_q.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("s_ready", {31'd0, s_ready}, {31'd0, mdl_sready});
      check("m_valid", {31'd0, m_valid}, {31'd0, mdl_q.size() > 0});
      check("busy", {31'd0, busy}, {31'd0, (mdl_in != 0) || (mdl_wait != 0) || (mdl_q.size() > 0)});
      if (mdl_q.size() > 0) check("m_data", {24'd0, m_data}, {24'd0, mdl_q[0]});
      check("A_o", A_o, mdl_word(0));
      check("B_o", B_o, mdl_word(1));
      check("C_o", C_o, mdl_word(2));
      check("D_o", D_o, mdl_word(3));
    end
  end

  logic [7:0] v_id[16]   = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4,
                             8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] v_beta[16] = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0,
                             8'd5, 8'd6, 8'd7, 8'd8, 8'd1, 8'd0, 8'd0, 8'd1};
  logic [7:0] v_wrap[16] = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd200, 8'd0, 8'd0, 8'd128,
                             8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] cap[$];

  task automatic send(input logic [7:0] ops[16], input int n, input bit gaps, input bit chk_first);
    int idx = 0;
    int guard = 0;
    bit acc;
    while (idx < n && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (chk_first && guard == 1) check("s_ready_back_to_back", {31'd0, s_ready}, 32'd1);
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data  = ops[idx];
      acc = s_valid && s_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    if (idx < n) check("send_timeout", idx, n);
    #1 s_valid = 1'b0;
  endtask

  task automatic recv(input int n, input int stall, output int lat);
    int got = 0;
    int cnt = 0;
    int guard = 0;
    int w = 0;
    lat = -1;
    cap.delete();
    while (got < n && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (lat < 0) begin
        if (m_valid) lat = w;
        else w++;
      end
      if (m_valid) begin
        m_ready = (cnt >= stall);
        if (m_ready) begin
          cap.push_back(m_data);
          got++;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        m_ready = (stall == 0);
      end
      @(posedge clk);
    end
    if (got < n) check("recv_timeout", got, n);
    #1 m_ready = 1'b0;
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_m_data"}, {24'd0, m_data}, 32'd0);
    check({tag, "_ops"}, A_o | B_o | C_o | D_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] cap_word();
    logic [31:0] r;
    r = 32'hxxxxxxxx;
    if (cap.size() == 4) r = {cap[0], cap[1], cap[2], cap[3]};
    return r;
  endfunction

  initial begin
    int lat;
    #3;
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_A_o", A_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_release", {31'd0, s_ready}, 32'd1);

    send(v_id, 16, 1'b0, 1'b0);
    recv(4, 0, lat);
    check("identity_latency", lat, 32'd2);
    check("identity_result", cap_word(), 32'h02040608);

    send(v_beta, 16, 1'b0, 1'b0);
    recv(4, 0, lat);
    check("beta_result", cap_word(), 32'h05060708);

    send(v_wrap, 16, 1'b0, 1'b0);
    recv(4, 0, lat);
    check("wrap_result", cap_word(), 32'h90000000);

    send(v_id, 16, 1'b1, 1'b0);
    recv(4, 5, lat);
    check("backpressure_result", cap_word(), 32'h02040608);

    send(v_id, 9, 1'b0, 1'b0);
    reset_pulse("rst_mid_load");
    send(v_id, 16, 1'b0, 1'b0);
    recv(4, 0, lat);
    check("after_load_reset_result", cap_word(), 32'h02040608);

    send(v_beta, 16, 1'b0, 1'b0);
    recv(2, 0, lat);
    reset_pulse("rst_mid_send");
    send(v_id, 16, 1'b0, 1'b0);
    recv(4, 0, lat);
    check("after_send_reset_result", cap_word(), 32'h02040608);

    send(v_id, 16, 1'b0, 1'b0);
    recv(4, 0, lat);
    check("b2b_first_result", cap_word(), 32'h02040608);
    send(v_beta, 16, 1'b0, 1'b1);
    recv(4, 0, lat);
    check("b2b_second_result", cap_word(), 32'h05060708);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
